// File: rtl/moesi_pkg.sv
// Shared MOESI encodings, bus/snoop opcodes and the snoop transition function
// used by the per-core coherence state array.
package moesi_pkg;

  localparam logic [2:0] ST_M = 3'b000;
  localparam logic [2:0] ST_O = 3'b001;
  localparam logic [2:0] ST_E = 3'b010;
  localparam logic [2:0] ST_S = 3'b011;
  localparam logic [2:0] ST_I = 3'b100;

  localparam logic [1:0] SNP_READ  = 2'd0;
  localparam logic [1:0] SNP_WRITE = 2'd1;
  localparam logic [1:0] SNP_INV   = 2'd2;
  localparam logic [1:0] SNP_NOP   = 2'd3;

  localparam logic [1:0] BUS_RD   = 2'd0;
  localparam logic [1:0] BUS_RDX  = 2'd1;
  localparam logic [1:0] BUS_UPGR = 2'd2;

  typedef struct packed {
    logic [2:0] next_state;
    logic       provide_data;
    logic       shared;
    logic       invalidated;
  } snp_result_t;

  // Unused encodings read back from the array behave as Invalid.
  function automatic logic [2:0] moesi_norm(input logic [2:0] st);
    logic [2:0] r;
    case (st)
      ST_M, ST_O, ST_E, ST_S: r = st;
      default:                r = ST_I;
    endcase
    return r;
  endfunction

  function automatic snp_result_t moesi_snoop_next(input logic [2:0] state,
                                                   input logic [1:0] typ);
    snp_result_t r;
    logic [2:0]  st;
    st             = moesi_norm(state);
    r.next_state   = st;
    r.provide_data = 1'b0;
    r.shared       = 1'b0;
    r.invalidated  = 1'b0;
    case (typ)
      SNP_INV: begin
        r.shared      = (st != ST_I);
        r.invalidated = (st != ST_I);
        r.next_state  = ST_I;
      end
      SNP_WRITE: begin
        r.shared       = (st != ST_I);
        r.invalidated  = (st != ST_I);
        r.provide_data = (st == ST_M) || (st == ST_O);
        r.next_state   = ST_I;
      end
      SNP_READ: begin
        r.shared = (st != ST_I);
        case (st)
          ST_M, ST_O: begin
            r.next_state   = ST_O;
            r.provide_data = 1'b1;
          end
          ST_E: begin
            r.next_state   = ST_S;
            r.provide_data = 1'b1;
          end
          default: r.next_state = st;
        endcase
      end
      default: r.next_state = st;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/moesi_state_array_if.sv
// Core-side request/response, bus handshake, snoop and statistics signals of
// the MOESI state array; slave is the array, master is its environment.
interface moesi_state_array_if #(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int CNT_W     = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx;
  logic             req_write;
  logic             resp_valid;
  logic             resp_hit;
  logic [2:0]       resp_state;
  logic             bus_req_valid;
  logic [1:0]       bus_req_type;
  logic [IDX_W-1:0] bus_req_idx;
  logic             bus_done;
  logic             bus_shared;
  logic             snp_valid;
  logic [IDX_W-1:0] snp_idx;
  logic [1:0]       snp_type;
  logic             snp_resp_valid;
  logic             snp_provide_data;
  logic             snp_shared;
  logic             snp_invalidated;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_misses;

  modport slave (
    input  req_valid, req_idx, req_write, bus_done, bus_shared,
           snp_valid, snp_idx, snp_type,
    output req_ready, resp_valid, resp_hit, resp_state,
           bus_req_valid, bus_req_type, bus_req_idx,
           snp_resp_valid, snp_provide_data, snp_shared, snp_invalidated,
           stat_hits, stat_misses
  );

  modport master (
    output req_valid, req_idx, req_write, bus_done, bus_shared,
           snp_valid, snp_idx, snp_type,
    input  req_ready, resp_valid, resp_hit, resp_state,
           bus_req_valid, bus_req_type, bus_req_idx,
           snp_resp_valid, snp_provide_data, snp_shared, snp_invalidated,
           stat_hits, stat_misses
  );
endinterface

// File: rtl/moesi_line_next.sv
// Local-request decision for one line: hit or bus transaction, the bus
// opcode needed on a miss/upgrade, and the line state after a hit.
module moesi_line_next
  import moesi_pkg::*;
(
  input  logic [2:0] state,
  input  logic       write,
  output logic       hit,
  output logic [1:0] bus_type,
  output logic [2:0] hit_state
);

  logic [2:0] st_s;
  assign st_s = moesi_norm(state);

  // Classify the request against the current line state.
  always_comb begin
    hit       = 1'b0;
    bus_type  = BUS_RD;
    hit_state = st_s;
    case (st_s)
      ST_M, ST_E: begin
        hit       = 1'b1;
        hit_state = write ? ST_M : st_s;
      end
      ST_O, ST_S: begin
        hit      = ~write;
        bus_type = write ? BUS_UPGR : BUS_RD;
      end
      default: begin
        hit      = 1'b0;
        bus_type = write ? BUS_RDX : BUS_RD;
      end
    endcase
  end

endmodule

// File: rtl/moesi_state_array.sv
// Per-core MOESI state store: serialises local requests through an
// IDLE/BUS/RESP controller and services one registered snoop per cycle.
module moesi_state_array
  import moesi_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  moesi_state_array_if.slave   port
);

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_BUS  = 2'd1;
  localparam logic [1:0] FSM_RESP = 2'd2;

  logic [1:0]       fsm_r, fsm_nxt_s;
  logic [2:0]       lines_r [NUM_LINES];
  logic [IDX_W-1:0] lat_idx_r;
  logic             lat_write_r;
  logic             resp_hit_r;
  logic [2:0]       resp_state_r;
  logic             snp_resp_valid_r, snp_provide_r, snp_shared_r, snp_inv_r;
  logic [CNT_W-1:0] hits_r, misses_r;

  logic [IDX_W-1:0] cur_idx_s, loc_idx_s;
  logic             cur_write_s;
  logic [2:0]       cur_state_s, fill_state_s, loc_state_s, snp_base_s, fill_final_s;
  logic             dec_hit_s;
  logic [1:0]       dec_bus_type_s;
  logic [2:0]       dec_hit_state_s;
  logic             req_ready_s, accept_s, fill_s, loc_we_s;
  snp_result_t      snp_res_s;

  moesi_line_next u_line_next (
    .state     (cur_state_s),
    .write     (cur_write_s),
    .hit       (dec_hit_s),
    .bus_type  (dec_bus_type_s),
    .hit_state (dec_hit_state_s)
  );

  // The decoder looks at the incoming request in IDLE and at the latched
  // request in BUS, so the bus opcode tracks snoops against the pending line.
  always_comb begin
    cur_idx_s    = (fsm_r == FSM_IDLE) ? port.req_idx   : lat_idx_r;
    cur_write_s  = (fsm_r == FSM_IDLE) ? port.req_write : lat_write_r;
    cur_state_s  = moesi_norm(lines_r[cur_idx_s]);
    req_ready_s  = (fsm_r == FSM_IDLE) &&
                   !(port.snp_valid && (port.snp_idx == port.req_idx));
    accept_s     = port.req_valid && req_ready_s;
    fill_s       = (fsm_r == FSM_BUS) && port.bus_done;
    fill_state_s = (dec_bus_type_s == BUS_RD) ? (port.bus_shared ? ST_S : ST_E) : ST_M;
    loc_idx_s    = cur_idx_s;
    loc_state_s  = fill_state_s;
    if (fill_s) begin
      loc_we_s = 1'b1;
    end else if (accept_s && dec_hit_s && cur_write_s) begin
      loc_we_s    = 1'b1;
      loc_state_s = ST_M;
    end else begin
      loc_we_s = 1'b0;
    end
    // A snoop colliding with a local write sees the freshly written state.
    snp_base_s   = (loc_we_s && (loc_idx_s == port.snp_idx)) ? loc_state_s
                                                             : lines_r[port.snp_idx];
    snp_res_s    = moesi_snoop_next(snp_base_s, port.snp_type);
    fill_final_s = (port.snp_valid && (port.snp_idx == lat_idx_r)) ? snp_res_s.next_state
                                                                  : fill_state_s;
  end

  // Controller next-state.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      FSM_IDLE: fsm_nxt_s = accept_s ? (dec_hit_s ? FSM_RESP : FSM_BUS) : FSM_IDLE;
      FSM_BUS:  fsm_nxt_s = fill_s ? FSM_RESP : FSM_BUS;
      FSM_RESP: fsm_nxt_s = FSM_IDLE;
      default:  fsm_nxt_s = FSM_IDLE;
    endcase
  end

  // Controller state, latched request, completion result and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r        <= FSM_IDLE;
      lat_idx_r    <= {IDX_W{1'b0}};
      lat_write_r  <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_state_r <= ST_I;
      hits_r       <= {CNT_W{1'b0}};
      misses_r     <= {CNT_W{1'b0}};
    end else begin
      fsm_r <= fsm_nxt_s;
      if (accept_s) begin
        lat_idx_r   <= port.req_idx;
        lat_write_r <= port.req_write;
      end
      if (accept_s && dec_hit_s) begin
        resp_hit_r   <= 1'b1;
        resp_state_r <= dec_hit_state_s;
        if (hits_r != {CNT_W{1'b1}}) hits_r <= hits_r + CNT_W'(1);
      end else if (fill_s) begin
        resp_hit_r   <= 1'b0;
        resp_state_r <= fill_final_s;
        if (misses_r != {CNT_W{1'b1}}) misses_r <= misses_r + CNT_W'(1);
      end
    end
  end

  // Line state array: snoop result overrides a same-line local write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) lines_r[i] <= ST_I;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (port.snp_valid && (port.snp_idx == IDX_W'(i))) begin
          lines_r[i] <= snp_res_s.next_state;
        end else if (loc_we_s && (loc_idx_s == IDX_W'(i))) begin
          lines_r[i] <= loc_state_s;
        end
      end
    end
  end

  // Registered snoop response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snp_resp_valid_r <= 1'b0;
      snp_provide_r    <= 1'b0;
      snp_shared_r     <= 1'b0;
      snp_inv_r        <= 1'b0;
    end else begin
      snp_resp_valid_r <= port.snp_valid;
      snp_provide_r    <= port.snp_valid & snp_res_s.provide_data;
      snp_shared_r     <= port.snp_valid & snp_res_s.shared;
      snp_inv_r        <= port.snp_valid & snp_res_s.invalidated;
    end
  end

  assign port.req_ready        = req_ready_s;
  assign port.resp_valid       = (fsm_r == FSM_RESP);
  assign port.resp_hit         = resp_hit_r;
  assign port.resp_state       = resp_state_r;
  assign port.bus_req_valid    = (fsm_r == FSM_BUS);
  assign port.bus_req_type     = (fsm_r == FSM_BUS) ? dec_bus_type_s : BUS_RD;
  assign port.bus_req_idx      = (fsm_r == FSM_BUS) ? lat_idx_r : {IDX_W{1'b0}};
  assign port.snp_resp_valid   = snp_resp_valid_r;
  assign port.snp_provide_data = snp_provide_r;
  assign port.snp_shared       = snp_shared_r;
  assign port.snp_invalidated  = snp_inv_r;
  assign port.stat_hits        = hits_r;
  assign port.stat_misses      = misses_r;

endmodule

// File: doc/moesi_state_array.md
# moesi_state_array

Per-core coherence state store holding MOESI state for NUM_LINES cache lines. It serialises local read/write requests and resolves misses and upgrades via a bus request/done handshake that carries a shared indication. It also services one snoop per cycle with a registered response. It sits between a core's L1 controller and the snooping bus interface, one instance per core.

## Interface
- NUM_LINES, 16: number of tracked lines; power of two, at least 2.
- IDX_W, $clog2(NUM_LINES): line index width.
- CNT_W, 16: width of the saturating hit/miss statistics counters.
- clk in 1: single clock; all state updates on the rising edge.
- rst in 1: reset, asynchronous, active-high.
- req_valid in 1: local request valid.
- req_ready out 1: local request accepted when req_valid && req_ready.
- req_idx in IDX_W: local line index.
- req_write in 1: 1 = write, 0 = read.
- resp_valid out 1: one-cycle completion pulse.
- resp_hit out 1: request completed without a bus transaction.
- resp_state out 3: line state after completion.
- bus_req_valid out 1: bus transaction requested; held until bus_done.
- bus_req_type out 2: 0 = RD, 1 = RDX, 2 = UPGR.
- bus_req_idx out IDX_W: line of the outstanding transaction.
- bus_done in 1: transaction complete; sampled only while bus_req_valid.
- bus_shared in 1: another cache holds the line; valid with bus_done.
- snp_valid in 1: snoop valid; never stalled.
- snp_idx in IDX_W: snooped line.
- snp_type in 2: 0 = READ, 1 = WRITE (RdX/Upgr), 2 = INV, 3 = reserved (no-op).
- snp_resp_valid out 1: registered snoop response, one cycle after snp_valid.
- snp_provide_data out 1: this cache supplies data.
- snp_shared out 1: line was valid (not I) before the snoop.
- snp_invalidated out 1: line transitioned to I.
- stat_hits out CNT_W: saturating count of hit completions.
- stat_misses out CNT_W: saturating count of bus-resolved completions.

## Operation
- State encoding: M = 000, O = 001, E = 010, S = 011, I = 100. Any other value read from the array is treated as I.
- Controller FSM has three states: IDLE, BUS, RESP.
  - IDLE: req_ready = 1, except in a cycle where snp_valid is high and snp_idx == req_idx.
  - IDLE, accepted read with line not I: hit; state unchanged; go to RESP.
  - IDLE, accepted write with line E or M: hit; line set to M; go to RESP.
  - IDLE, accepted write with line S or O: go to BUS, type UPGR.
  - IDLE, accepted request with line I: go to BUS, type RD for a read or RDX for a write.
  - BUS: bus_req_valid = 1 and bus_req_idx = latched index. bus_req_type is recomputed each cycle from the current line state. An UPGR whose line was snoop-invalidated becomes RDX.
  - BUS, on bus_done: RD fills S if bus_shared, else E; RDX and UPGR set the line to M. Then go to RESP.
  - RESP: resp_valid = 1 and resp_state = final line state; return to IDLE.
- Snoop rules, applied to the line selected by snp_idx:
  - INV: line goes to I; snp_invalidated = 1 if the line was valid; no data.
  - WRITE from M or O: line goes to I; provide data; snp_invalidated = 1.
  - WRITE from E or S: line goes to I; snp_invalidated = 1; no data.
  - READ from M or O: line goes to O; provide data.
  - READ from E: line goes to S; provide data.
  - READ from S or I: no state change; no data.
- Fill/snoop same-cycle collision: if bus_done coincides with a snoop to the same idx, the snoop is applied on top of the fill state. Example: RDX fill to M plus snoop READ ends in O with snp_provide_data = 1.
- Counters saturate at all ones. stat_hits increments on a hit completion; stat_misses increments on a BUS-path completion.

## Timing
- Reset values: all lines I; FSM IDLE; req_ready 1; resp_valid, bus_req_valid and snp_resp_valid 0; all snoop flags 0; resp_state I; bus_req_type 0; bus_req_idx 0; counters 0.
- Reset asserted mid-transaction aborts it: bus_req_valid drops asynchronously and no resp_valid follows.
- Hit latency: accept at cycle N, resp_valid at N+1.
- Miss/upgrade latency: bus_req_valid from N+1; resp_valid the cycle after bus_done.
- Array write for a hit or snoop is visible to a request or snoop in the following cycle.
- Snoop response is registered: snp_resp_valid exactly one cycle after snp_valid, one per snoop, back-to-back capable.
- bus_done is ignored when bus_req_valid = 0.

## Structure
- moesi_pkg holds:
  - the state localparams;
  - the snoop-type and bus-type localparams;
  - the function moesi_snoop_next(state, type), returning next state and the three snoop flags.
- One combinational sub-module, moesi_line_next, computes the local-request decision: hit/miss, bus type, and hit next state.

## Test plan
- Read idx 3 from reset, bus_done with bus_shared = 0 → bus_req_type RD, resp_state E, resp_hit 0, stat_misses 1. Repeat the read → hit, resp_state E one cycle later, stat_hits 1.
- Line 5 in S, write idx 5 → UPGR. Snoop INV on idx 5 before bus_done → bus_req_type switches to RDX, snp_invalidated 1; bus_done → resp_state M.
- Line 7 in M, snoop READ idx 7 → snp_provide_data 1, snp_shared 1, line O. Snoop WRITE idx 7 → provide data, invalidated, line I.
- Local request and snoop to the same idx in the same cycle → req_ready 0 that cycle; request accepted the next cycle using the post-snoop state.
- RDX bus_done on idx 2 with simultaneous snoop READ idx 2 → resp_state O, snp_provide_data 1. Then assert rst during a pending bus_req → all outputs return to reset values immediately.
